// File: rtl/joybus_poller.sv
// Round-robin Joybus status poller: one shared bit engine serving CHANNELS controller ports.
// Optional feature macro: JOYBUS_RUMBLE_EN puts rumble[ch] into bit 0 of the status command.
module joybus_poller #(
    parameter int CHANNELS   = 2,
    parameter int US_CYCLES  = 50,
    parameter int RESP_BITS  = 64,
    parameter int POLL_US    = 1000,
    parameter int TIMEOUT_US = 100
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          enable,
    input  logic [CHANNELS-1:0]           line_in,
    output logic [CHANNELS-1:0]           line_oe,
    input  logic [CHANNELS-1:0]           rumble,
    output logic [CHANNELS*RESP_BITS-1:0] data_out,
    output logic [CHANNELS-1:0]           update,
    output logic [CHANNELS-1:0]           present,
    output logic                          busy
);
    localparam int CW   = $clog2(4*US_CYCLES);
    localparam int BW   = $clog2(RESP_BITS+1);
    localparam int CHW  = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
    localparam int SW   = (POLL_US > 1) ? $clog2(POLL_US) : 1;
    localparam int TMAX = (TIMEOUT_US > 6) ? TIMEOUT_US : 6;
    localparam int TW   = $clog2(TMAX);

    localparam logic [CW-1:0]       C_1US    = CW'(US_CYCLES-1);
    localparam logic [CW-1:0]       C_2US    = CW'(2*US_CYCLES-1);
    localparam logic [CW-1:0]       C_3US    = CW'(3*US_CYCLES-1);
    localparam logic [CW-1:0]       C_4US    = CW'(4*US_CYCLES-1);
    localparam logic [TW-1:0]       T_FIRST  = TW'(TIMEOUT_US-1);
    localparam logic [TW-1:0]       T_NEXT   = TW'(5);
    localparam logic [SW-1:0]       P_LAST   = SW'(POLL_US-1);
    localparam logic [BW-1:0]       RB_LAST  = BW'(RESP_BITS-1);
    localparam logic [CHW-1:0]      CH_LAST  = CHW'(CHANNELS-1);
    localparam logic [CHANNELS-1:0] CH_ONE   = CHANNELS'(1);

    typedef enum logic [3:0] {
        ST_IDLE, ST_TX_LOW, ST_TX_HIGH, ST_TX_STOP,
        ST_RX_WAIT, ST_RX_SAMPLE, ST_DONE, ST_FAIL, ST_NEXT
    } state_t;

    state_t                 state;
    logic [CHW-1:0]         ch;
    logic [CW-1:0]          cyc;
    logic [TW-1:0]          us;
    logic [4:0]             txbit;
    logic [BW-1:0]          rxbit;
    logic [23:0]            cmd;
    logic [RESP_BITS-1:0]   shreg;
    logic [CW-1:0]          slot_cyc;
    logic [SW-1:0]          slot_us;
    logic                   slot_exp;
    logic [CHANNELS-1:0]    line_p0, line_p1;
    logic                   sel_p2;
    logic                   sel, fall, drive, slot_due, start, rumble_bit;

    function automatic logic [23:0] cmd_word(input logic r);
        return {23'h200180, r};
    endfunction

`ifdef JOYBUS_RUMBLE_EN
    assign rumble_bit = rumble[ch];
`else
    logic unused_rumble;
    assign rumble_bit    = 1'b0;
    assign unused_rumble = ^rumble;
`endif

    // p0/p1: two-flop synchroniser on every pin
    always_ff @(posedge clk) begin
        line_p0 <= line_in;
        line_p1 <= line_p0;
    end

    // p2: delayed copy of the selected channel for falling-edge detection
    assign sel = line_p1[ch];
    always_ff @(posedge clk) begin
        sel_p2 <= sel;
    end
    assign fall = sel_p2 & ~sel;

    assign drive    = (state == ST_TX_LOW) || ((state == ST_TX_STOP) && (cyc <= C_1US));
    assign slot_due = slot_exp || ((slot_us == P_LAST) && (slot_cyc == C_1US));
    assign start    = (state == ST_IDLE) && enable && slot_due;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state    <= ST_IDLE;
            ch       <= '0;
            busy     <= 1'b0;
            line_oe  <= '0;
            update   <= '0;
            present  <= '0;
            data_out <= '0;
            slot_exp <= 1'b1;
            slot_cyc <= '0;
            slot_us  <= '0;
            cyc      <= '0;
            us       <= '0;
            txbit    <= '0;
            rxbit    <= '0;
            cmd      <= '0;
            shreg    <= '0;
        end else begin
            update  <= '0;
            line_oe <= drive ? (CH_ONE << ch) : '0;

            // Slot timer measures time since the last slot start, saturating once due
            if (start) begin
                slot_exp <= 1'b0;
                slot_cyc <= '0;
                slot_us  <= '0;
            end else if (!slot_exp) begin
                if (slot_cyc == C_1US) begin
                    slot_cyc <= '0;
                    if (slot_us == P_LAST) slot_exp <= 1'b1;
                    else                   slot_us  <= slot_us + 1'b1;
                end else begin
                    slot_cyc <= slot_cyc + 1'b1;
                end
            end

            case (state)
                ST_IDLE: begin
                    if (start) begin
                        cmd   <= cmd_word(rumble_bit);
                        cyc   <= '0;
                        txbit <= '0;
                        busy  <= 1'b1;
                        state <= ST_TX_LOW;
                    end
                end
                ST_TX_LOW: begin
                    cyc <= cyc + 1'b1;
                    if (cyc == (cmd[23] ? C_1US : C_3US)) state <= ST_TX_HIGH;
                end
                ST_TX_HIGH: begin
                    if (cyc == C_4US) begin
                        cyc <= '0;
                        cmd <= {cmd[22:0], 1'b0};
                        if (txbit == 5'd23) begin
                            state <= ST_TX_STOP;
                        end else begin
                            txbit <= txbit + 1'b1;
                            state <= ST_TX_LOW;
                        end
                    end else begin
                        cyc <= cyc + 1'b1;
                    end
                end
                ST_TX_STOP: begin
                    if (cyc == C_4US) begin
                        cyc   <= '0;
                        us    <= '0;
                        rxbit <= '0;
                        state <= ST_RX_WAIT;
                    end else begin
                        cyc <= cyc + 1'b1;
                    end
                end
                ST_RX_WAIT: begin
                    if (fall) begin
                        cyc   <= '0;
                        state <= ST_RX_SAMPLE;
                    end else if (cyc == C_1US) begin
                        cyc <= '0;
                        if (us == ((rxbit == '0) ? T_FIRST : T_NEXT)) state <= ST_FAIL;
                        else                                         us    <= us + 1'b1;
                    end else begin
                        cyc <= cyc + 1'b1;
                    end
                end
                ST_RX_SAMPLE: begin
                    if (cyc == C_2US) begin
                        shreg <= {shreg[RESP_BITS-2:0], sel};
                        cyc   <= '0;
                        us    <= '0;
                        if (rxbit == RB_LAST) begin
                            state <= ST_DONE;
                        end else begin
                            rxbit <= rxbit + 1'b1;
                            state <= ST_RX_WAIT;
                        end
                    end else begin
                        cyc <= cyc + 1'b1;
                    end
                end
                ST_DONE: begin
                    data_out[int'(ch)*RESP_BITS +: RESP_BITS] <= shreg;
                    update[ch]  <= 1'b1;
                    present[ch] <= 1'b1;
                    state       <= ST_NEXT;
                end
                ST_FAIL: begin
                    present[ch] <= 1'b0;
                    state       <= ST_NEXT;
                end
                ST_NEXT: begin
                    ch    <= (ch == CH_LAST) ? '0 : ch + 1'b1;
                    busy  <= 1'b0;
                    state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_joybus_poller.sv
// Bench for joybus_poller: decodes the command waveform, plays controller replies and
// checks published reports against a slot-level model of expected channel results.
module tb_joybus_poller;
    localparam int CH = 2;
    localparam int US = 4;
    localparam int RB = 64;
    localparam int PU = 1000;
    localparam int TU = 100;

    logic              clk = 1'b0;
    logic              rst;
    logic              enable;
    logic [CH-1:0]     line_in;
    logic [CH-1:0]     line_oe;
    logic [CH-1:0]     rumble;
    logic [CH*RB-1:0]  data_out;
    logic [CH-1:0]     update;
    logic [CH-1:0]     present;
    logic              busy;
    logic [CH-1:0]     dev_low;

    int total = 0;
    int bad   = 0;
    int cycn  = 0;
    int oe_multi = 0;
    int upd_cnt [CH] = '{default: 0};
    logic [RB-1:0] upd_snap [CH];
    logic [RB-1:0] exp_data [CH];
    logic [CH-1:0] exp_present;

    joybus_poller #(
        .CHANNELS(CH), .US_CYCLES(US), .RESP_BITS(RB), .POLL_US(PU), .TIMEOUT_US(TU)
    ) dut (
        .clk(clk), .rst(rst), .enable(enable), .line_in(line_in), .line_oe(line_oe),
        .rumble(rumble), .data_out(data_out), .update(update), .present(present), .busy(busy)
    );

    always #5 clk = ~clk;

    // Open-drain wire: low if either the poller or the controller pulls it
    assign line_in = ~(line_oe | dev_low);

    always @(posedge clk) cycn <= cycn + 1;

    always @(negedge clk) begin
        if ($countones(line_oe) > 1) oe_multi <= oe_multi + 1;
        for (int k = 0; k < CH; k++) begin
            if (update[k]) begin
                upd_cnt[k]  <= upd_cnt[k] + 1;
                upd_snap[k] <= data_out[k*RB +: RB];
            end
        end
    end

    task automatic chk(input string tag, input logic [RB-1:0] obs, input logic [RB-1:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk_range(input string tag, input int obs, input int lo, input int hi);
        total++;
        assert (obs >= lo && obs <= hi) else begin
            bad++;
            $error("FAIL %s: observed=%0d expected range %0d..%0d", tag, obs, lo, hi);
        end
    endtask

    function automatic logic [23:0] exp_cmd(input int c);
`ifdef JOYBUS_RUMBLE_EN
        return 24'h400300 | {23'b0, rumble[c]};
`else
        return 24'h400300;
`endif
    endfunction

    // mode: 0 full reply, 1 silent, 2 reply cut after 10 bits, 3 reset during TX,
    //       4 full reply with enable dropped right after the slot starts
    task automatic run_slot(input int c, input int mode, input logic [RB-1:0] val, output int t_start);
        int t, lo, hi, other_hi, nb, u_c, u_o, t_rel, t_last, t_end;
        logic [23:0] cmd;
        logic fmt_ok;
        other_hi = 0; fmt_ok = 1'b1; cmd = '0; t_last = 0;
        u_c = upd_cnt[c]; u_o = upd_cnt[1-c];
        t = 0;
        while (!line_oe[c] && t < 5000) begin
            if (line_oe[1-c]) other_hi++;
            @(negedge clk); t++;
        end
        chk("slot_start", 64'(line_oe[c]), 64'd1);
        t_start = cycn;
        if (mode == 3) begin
            rst = 1'b0;
            @(negedge clk);
            chk("rst_oe", 64'(line_oe), 64'd0);
            chk("rst_busy", 64'(busy), 64'd0);
            chk("rst_present", 64'(present), 64'd0);
            chk("rst_slice0", data_out[0 +: RB], 64'd0);
            chk("rst_slice1", data_out[RB +: RB], 64'd0);
            exp_data[0] = '0; exp_data[1] = '0; exp_present = '0;
            rst = 1'b1;
            return;
        end
        if (mode == 4) enable = 1'b0;
        for (int i = 0; i < 24; i++) begin
            lo = 0;
            while (line_oe[c] && lo < 20) begin
                lo++; if (line_oe[1-c]) other_hi++; @(negedge clk);
            end
            hi = 0;
            while (!line_oe[c] && hi < 20) begin
                hi++; if (line_oe[1-c]) other_hi++; @(negedge clk);
            end
            if (lo == US && hi == 3*US)      cmd = {cmd[22:0], 1'b1};
            else if (lo == 3*US && hi == US) cmd = {cmd[22:0], 1'b0};
            else begin fmt_ok = 1'b0; cmd = {cmd[22:0], 1'b0}; end
        end
        lo = 0;
        while (line_oe[c] && lo < 20) begin lo++; @(negedge clk); end
        t_rel = cycn;
        chk("cmd_word", 64'(cmd), 64'(exp_cmd(c)));
        chk("bit_shape", 64'(fmt_ok), 64'd1);
        chk("stop_len", 64'(lo), 64'(US));
        if (mode == 0 || mode == 2 || mode == 4) begin
            nb = (mode == 2) ? 10 : RB;
            repeat (16 + $urandom_range(0, 40)) @(negedge clk);
            for (int i = 0; i < nb; i++) begin
                t_last = cycn;
                dev_low[c] = 1'b1; repeat (val[RB-1-i] ? US : 3*US) @(negedge clk);
                dev_low[c] = 1'b0; repeat (val[RB-1-i] ? 3*US : US) @(negedge clk);
            end
            if (mode != 2) begin
                dev_low[c] = 1'b1; repeat (US) @(negedge clk); dev_low[c] = 1'b0;
            end
        end
        t = 0;
        while (busy && t < 3000) begin @(negedge clk); t++; end
        t_end = cycn;
        chk("busy_drop", 64'(busy), 64'd0);
        if (mode == 1) chk_range("silent_timeout", t_end - t_rel, TU*US + 8, TU*US + 18);
        if (mode == 2) chk_range("quiet_timeout", t_end - t_last, 6*US + 9, 6*US + 17);
        if (mode == 0 || mode == 4) begin
            exp_data[c] = val; exp_present[c] = 1'b1;
            chk("upd_data", upd_snap[c], val);
        end else begin
            exp_present[c] = 1'b0;
        end
        chk("upd_count", 64'(upd_cnt[c] - u_c), (mode == 0 || mode == 4) ? 64'd1 : 64'd0);
        chk("upd_other", 64'(upd_cnt[1-c] - u_o), 64'd0);
        chk("slice0", data_out[0 +: RB], exp_data[0]);
        chk("slice1", data_out[RB +: RB], exp_data[1]);
        chk("present", 64'(present), 64'(exp_present));
        chk("other_oe", 64'(other_hi), 64'd0);
    endtask

    initial begin
        int ts0, ts1, ts2, ts3, ts4, ts5, ts6, ts7, t_rr, quiet;
        dev_low = '0; rumble = 2'b10; enable = 1'b1; rst = 1'b0;
        exp_data[0] = '0; exp_data[1] = '0; exp_present = '0;
        repeat (3) @(negedge clk);
        chk("reset_oe", 64'(line_oe), 64'd0);
        chk("reset_busy", 64'(busy), 64'd0);
        chk("reset_present", 64'(present), 64'd0);
        chk("reset_update", 64'(update), 64'd0);
        chk("reset_data", data_out[0 +: RB] | data_out[RB +: RB], 64'd0);
        rst = 1'b1;
        @(negedge clk);
        chk("first_busy", 64'(busy), 64'd1);
        chk("first_oe_lag", 64'(line_oe), 64'd0);
        @(negedge clk);
        chk("first_oe", 64'(line_oe), 64'd1);

        run_slot(0, 0, 64'h0080_8080_8080_0000, ts0);
        run_slot(1, 1, '0, ts1);
        chk("period_ch1", 64'(ts1 - ts0), 64'(PU*US));
        run_slot(0, 0, {$urandom, $urandom}, ts2);
        chk("period_after_fail", 64'(ts2 - ts1), 64'(PU*US));
        run_slot(1, 0, {$urandom, $urandom}, ts3);
        run_slot(0, 2, {$urandom, $urandom}, ts4);
        chk("period_trunc", 64'(ts4 - ts3), 64'(PU*US));
        run_slot(1, 0, {$urandom, $urandom}, ts5);
        run_slot(0, 0, {$urandom, $urandom}, ts6);
        run_slot(1, 3, '0, ts7);
        t_rr = cycn;
        run_slot(0, 0, {$urandom, $urandom}, ts0);
        chk("post_rst_start", 64'(ts0 - t_rr), 64'd2);
        run_slot(1, 4, {$urandom, $urandom}, ts1);
        quiet = 0;
        repeat (PU*US + 500) begin
            @(negedge clk);
            if (line_oe != '0 || busy) quiet++;
        end
        chk("no_slot_disabled", 64'(quiet), 64'd0);
        chk("oe_onehot", 64'(oe_multi), 64'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
